// File: rtl/dmem_arbiter_if.sv
// Request/grant bundle for the two data-memory requesters (A = MEM stage, B = loader/debug)
// together with the datamemory control lines driven by the arbiter.
interface dmem_arbiter_if #(
   parameter int DM_ADDRESS = 9,
   parameter int DATA_W     = 32
);
   logic                  a_req,    b_req;
   logic                  a_we,     b_we;
   logic [DM_ADDRESS-1:0] a_addr,   b_addr;
   logic [DATA_W-1:0]     a_wd,     b_wd;
   logic [2:0]            a_funct3, b_funct3;
   logic                  a_gnt,    b_gnt;
   logic                  a_rvalid, b_rvalid;
   logic [DATA_W-1:0]     a_rdata,  b_rdata;
   logic                  MemRead,  MemWrite;
   logic [DM_ADDRESS-1:0] a;
   logic [DATA_W-1:0]     wd;
   logic [2:0]            Funct3;
   logic [DATA_W-1:0]     rd;
   logic                  busy;

   // Arbiter side
   modport slave (
      input  a_req, b_req, a_we, b_we, a_addr, b_addr, a_wd, b_wd, a_funct3, b_funct3, rd,
      output a_gnt, b_gnt, a_rvalid, b_rvalid, a_rdata, b_rdata,
             MemRead, MemWrite, a, wd, Funct3, busy
   );

   // Requesters plus datamemory side
   modport master (
      output a_req, b_req, a_we, b_we, a_addr, b_addr, a_wd, b_wd, a_funct3, b_funct3, rd,
      input  a_gnt, b_gnt, a_rvalid, b_rvalid, a_rdata, b_rdata,
             MemRead, MemWrite, a, wd, Funct3, busy
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter/sequencer for the shared data memory: one access cycle per grant,
// loads return registered data to the winning port one cycle later.
module dmem_arbiter #(
   parameter int DM_ADDRESS = 9,
   parameter int DATA_W     = 32
) (
   input  logic          clk,
   input  logic          reset,
   dmem_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ACC, RESP} state_t;

   state_t                state_q;
   logic                  last_b_q;
   logic                  win_b_q;
   logic                  we_q;
   logic                  a_gnt_q, b_gnt_q;
   logic                  a_rvalid_q, b_rvalid_q;
   logic                  mem_read_q, mem_write_q;
   logic                  busy_q;
   logic [DM_ADDRESS-1:0] addr_q;
   logic [DATA_W-1:0]     wd_q;
   logic [2:0]            funct3_q;
   logic [DATA_W-1:0]     a_rdata_q, b_rdata_q;

   logic                  win_b_d;
   logic                  we_d;
   logic [DM_ADDRESS-1:0] addr_d;
   logic [DATA_W-1:0]     wd_d;
   logic [2:0]            funct3_d;

   // B wins when it is the only requester, or on a tie when A had the previous grant
   assign win_b_d  = bus.b_req & (~bus.a_req | ~last_b_q);
   assign we_d     = win_b_d ? bus.b_we     : bus.a_we;
   assign addr_d   = win_b_d ? bus.b_addr   : bus.a_addr;
   assign wd_d     = win_b_d ? bus.b_wd     : bus.a_wd;
   assign funct3_d = win_b_d ? bus.b_funct3 : bus.a_funct3;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         last_b_q    <= 1'b1;
         win_b_q     <= 1'b0;
         we_q        <= 1'b0;
         a_gnt_q     <= 1'b0;
         b_gnt_q     <= 1'b0;
         a_rvalid_q  <= 1'b0;
         b_rvalid_q  <= 1'b0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         busy_q      <= 1'b0;
         addr_q      <= '0;
         wd_q        <= '0;
         funct3_q    <= '0;
         a_rdata_q   <= '0;
         b_rdata_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.a_req || bus.b_req) begin
                  win_b_q     <= win_b_d;
                  last_b_q    <= win_b_d;
                  we_q        <= we_d;
                  addr_q      <= addr_d;
                  wd_q        <= wd_d;
                  funct3_q    <= funct3_d;
                  mem_read_q  <= ~we_d;
                  mem_write_q <= we_d;
                  a_gnt_q     <= ~win_b_d;
                  b_gnt_q     <= win_b_d;
                  busy_q      <= 1'b1;
                  state_q     <= ACC;
               end
            end
            ACC: begin
               // The payload registers double as the memory bus, so clear them on the way out
               a_gnt_q     <= 1'b0;
               b_gnt_q     <= 1'b0;
               mem_read_q  <= 1'b0;
               mem_write_q <= 1'b0;
               addr_q      <= '0;
               wd_q        <= '0;
               funct3_q    <= '0;
               if (!we_q) begin
                  if (win_b_q) begin
                     b_rdata_q  <= bus.rd;
                     b_rvalid_q <= 1'b1;
                  end else begin
                     a_rdata_q  <= bus.rd;
                     a_rvalid_q <= 1'b1;
                  end
                  state_q <= RESP;
               end else begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            RESP: begin
               a_rvalid_q <= 1'b0;
               b_rvalid_q <= 1'b0;
               busy_q     <= 1'b0;
               state_q    <= IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.a_gnt    = a_gnt_q;
   assign bus.b_gnt    = b_gnt_q;
   assign bus.a_rvalid = a_rvalid_q;
   assign bus.b_rvalid = b_rvalid_q;
   assign bus.a_rdata  = a_rdata_q;
   assign bus.b_rdata  = b_rdata_q;
   assign bus.MemRead  = mem_read_q;
   assign bus.MemWrite = mem_write_q;
   assign bus.a        = addr_q;
   assign bus.wd       = wd_q;
   assign bus.Funct3   = funct3_q;
   assign bus.busy     = busy_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed scenarios followed by a randomized two-requester run scored against a
// transaction-level model of grant order, latency and memory contents.
module tb_dmem_arbiter;
   localparam int AW = 9;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   dmem_arbiter_if #(.DM_ADDRESS(AW), .DATA_W(DW)) bus();
   dmem_arbiter #(.DM_ADDRESS(AW), .DATA_W(DW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   logic [7:0]  mem    [512];
   logic [7:0]  shadow [512];
   logic [31:0] raw_w;

   function automatic logic [31:0] sx(input logic [31:0] w, input logic [2:0] f);
      case (f)
         3'b000:  return {{24{w[7]}}, w[7:0]};
         3'b001:  return {{16{w[15]}}, w[15:0]};
         3'b100:  return {24'h0, w[7:0]};
         3'b101:  return {16'h0, w[15:0]};
         default: return w;
      endcase
   endfunction

   // datamemory stand-in: combinational read, write on the falling edge
   assign raw_w  = {mem[bus.a + 9'd3], mem[bus.a + 9'd2], mem[bus.a + 9'd1], mem[bus.a]};
   assign bus.rd = (bus.MemRead === 1'b1) ? sx(raw_w, bus.Funct3) : 32'h0;

   always @(negedge clk) begin
      if (bus.MemWrite === 1'b1) begin
         mem[bus.a] = bus.wd[7:0];
         if (bus.Funct3[1:0] != 2'b00) mem[bus.a + 9'd1] = bus.wd[15:8];
         if (bus.Funct3[1:0] == 2'b10) begin
            mem[bus.a + 9'd2] = bus.wd[23:16];
            mem[bus.a + 9'd3] = bus.wd[31:24];
         end
      end
   end

   function automatic logic [31:0] shd_rd(input logic [8:0] ad, input logic [2:0] f);
      return sx({shadow[ad + 9'd3], shadow[ad + 9'd2], shadow[ad + 9'd1], shadow[ad]}, f);
   endfunction

   task automatic shd_wr(input logic [8:0] ad, input logic [31:0] d, input logic [2:0] f);
      shadow[ad] = d[7:0];
      if (f[1:0] != 2'b00) shadow[ad + 9'd1] = d[15:8];
      if (f[1:0] == 2'b10) begin
         shadow[ad + 9'd2] = d[23:16];
         shadow[ad + 9'd3] = d[31:24];
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit p, input logic r, input logic we, input logic [8:0] ad,
                        input logic [31:0] d, input logic [2:0] f);
      if (!p) begin
         bus.a_req = r; bus.a_we = we; bus.a_addr = ad; bus.a_wd = d; bus.a_funct3 = f;
      end else begin
         bus.b_req = r; bus.b_we = we; bus.b_addr = ad; bus.b_wd = d; bus.b_funct3 = f;
      end
   endtask

   task automatic drop(input bit p);
      if (!p) bus.a_req = 1'b0;
      else    bus.b_req = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 9'h0, 32'h0, 3'b000);
      drive(1'b1, 1'b0, 1'b0, 9'h0, 32'h0, 3'b000);
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (bus.busy !== 1'b0 && n < 10) begin
         tick();
         n++;
      end
      chk("idle_timeout", 32'(bus.busy), 32'h0);
   endtask

   // randomized-phase model state
   bit          pend   [2];
   logic        pwe    [2];
   logic [8:0]  pad    [2];
   logic [31:0] pwd    [2];
   logic [2:0]  pf3    [2];
   int          done_c [2];
   logic [31:0] exp_rd [2];
   int          g_cyc, v_cyc, free_c, ng, last_c;
   bit          g_b, v_b, last_b, wb;
   logic        g_we, rwe;
   logic [8:0]  g_ad, rad;
   logic [31:0] g_wd, v_data, rwd;
   logic [2:0]  g_f3, rf3;

   initial begin
      for (int i = 0; i < 512; i++) begin
         mem[i]    = 8'h00;
         shadow[i] = 8'h00;
      end
      reset = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 9'h0, 32'h0, 3'b000);
      drive(1'b1, 1'b0, 1'b0, 9'h0, 32'h0, 3'b000);
      #1;
      chk("rst_busy",    32'(bus.busy),    32'h0);
      chk("rst_gnt",     32'({bus.a_gnt, bus.b_gnt, bus.a_rvalid, bus.b_rvalid}), 32'h0);
      chk("rst_strobes", 32'({bus.MemRead, bus.MemWrite}), 32'h0);
      chk("rst_addr",    32'(bus.a),       32'h0);
      chk("rst_wd",      bus.wd,           32'h0);
      chk("rst_f3",      32'(bus.Funct3),  32'h0);
      chk("rst_a_rdata", bus.a_rdata,      32'h0);
      chk("rst_b_rdata", bus.b_rdata,      32'h0);
      tick();
      reset = 1'b0;

      // A load of a preloaded word
      {mem[19], mem[18], mem[17], mem[16]} = 32'hDEADBEEF;
      drive(1'b0, 1'b1, 1'b0, 9'h010, 32'h0, 3'b010);
      tick();
      $display("txn directed A LW addr=010");
      chk("a_ld_gnt",     32'(bus.a_gnt),   32'h1);
      chk("a_ld_memread", 32'(bus.MemRead), 32'h1);
      chk("a_ld_addr",    32'(bus.a),       32'h010);
      chk("a_ld_b_gnt",   32'(bus.b_gnt),   32'h0);
      drop(1'b0);
      tick();
      chk("a_ld_rvalid",  32'(bus.a_rvalid), 32'h1);
      chk("a_ld_rdata",   bus.a_rdata,       32'hDEADBEEF);
      chk("a_ld_memrd_off", 32'(bus.MemRead), 32'h0);
      chk("a_ld_b_quiet", 32'({bus.b_rvalid, bus.b_gnt}), 32'h0);
      chk("a_ld_b_rdata", bus.b_rdata,       32'h0);
      tick();
      chk("a_ld_idle",    32'({bus.busy, bus.a_rvalid}), 32'h0);

      // B store, then A reads it back
      drive(1'b1, 1'b1, 1'b1, 9'h020, 32'h12345678, 3'b010);
      tick();
      $display("txn directed B SW addr=020 data=12345678");
      chk("b_st_gnt",   32'(bus.b_gnt),    32'h1);
      chk("b_st_mw",    32'({bus.MemWrite, bus.MemRead}), 32'h2);
      chk("b_st_addr",  32'(bus.a),        32'h020);
      chk("b_st_wd",    bus.wd,            32'h12345678);
      chk("b_st_f3",    32'(bus.Funct3),   32'h2);
      drop(1'b1);
      tick();
      chk("b_st_no_rvalid", 32'(bus.b_rvalid), 32'h0);
      chk("b_st_idle",  32'({bus.busy, bus.MemWrite}), 32'h0);
      drive(1'b0, 1'b1, 1'b0, 9'h020, 32'h0, 3'b010);
      tick();
      $display("txn directed A LW addr=020");
      chk("a_rb_gnt",   32'(bus.a_gnt), 32'h1);
      drop(1'b0);
      tick();
      chk("a_rb_rdata", bus.a_rdata, 32'h12345678);
      tick();

      // continuous requests from both ports after reset
      do_reset();
      drive(1'b0, 1'b1, 1'b0, 9'h010, 32'h0, 3'b010);
      drive(1'b1, 1'b1, 1'b0, 9'h020, 32'h0, 3'b010);
      ng = 0;
      last_c = 0;
      for (int c = 0; c < 40 && ng < 4; c++) begin
         tick();
         if (bus.a_gnt === 1'b1 || bus.b_gnt === 1'b1) begin
            $display("txn rr grant %0d to %s at cycle %0d", ng, bus.b_gnt ? "B" : "A", c);
            chk("rr_onehot", 32'(bus.a_gnt & bus.b_gnt), 32'h0);
            chk("rr_port",   32'(bus.b_gnt), 32'(ng % 2));
            if (ng > 0) chk("rr_gap", 32'(c - last_c), 32'd3);
            last_c = c;
            ng++;
         end
      end
      chk("rr_count", 32'(ng), 32'd4);
      drop(1'b0);
      drop(1'b1);
      wait_idle();
      chk("rr_a_rdata", bus.a_rdata, 32'hDEADBEEF);
      chk("rr_b_rdata", bus.b_rdata, 32'h12345678);

      // B raised during A's access waits for the next IDLE
      drive(1'b0, 1'b1, 1'b0, 9'h010, 32'h0, 3'b010);
      tick();
      chk("late_a_gnt", 32'(bus.a_gnt), 32'h1);
      drop(1'b0);
      drive(1'b1, 1'b1, 1'b0, 9'h020, 32'h0, 3'b010);
      tick();
      chk("late_resp_no_b", 32'(bus.b_gnt), 32'h0);
      chk("late_a_rvalid",  32'(bus.a_rvalid), 32'h1);
      tick();
      chk("late_idle_no_b", 32'({bus.b_gnt, bus.busy}), 32'h0);
      tick();
      $display("txn directed late B LW addr=020");
      chk("late_b_gnt", 32'(bus.b_gnt), 32'h1);
      drop(1'b1);
      tick();
      chk("late_b_rvalid", 32'(bus.b_rvalid), 32'h1);
      chk("late_b_rdata",  bus.b_rdata, 32'h12345678);
      chk("late_a_keep",   bus.a_rdata, 32'hDEADBEEF);
      tick();

      // reset while an A load is in its access cycle
      drive(1'b0, 1'b1, 1'b0, 9'h010, 32'h0, 3'b010);
      tick();
      chk("rstacc_gnt", 32'({bus.a_gnt, bus.MemRead}), 32'h3);
      #1 reset = 1'b1;
      #1;
      chk("rstacc_strobes", 32'({bus.a_gnt, bus.MemRead, bus.busy}), 32'h0);
      drop(1'b0);
      tick();
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("rstacc_no_rvalid", 32'(bus.a_rvalid), 32'h0);
         tick();
      end
      chk("rstacc_rdata", bus.a_rdata, 32'h0);
      drive(1'b0, 1'b1, 1'b1, 9'h040, 32'hA5A5A5A5, 3'b010);
      drive(1'b1, 1'b1, 1'b1, 9'h044, 32'h5A5A5A5A, 3'b010);
      tick();
      $display("txn directed tie after reset");
      chk("rstacc_tie_a", 32'({bus.a_gnt, bus.b_gnt}), 32'h2);
      drop(1'b0);
      tick();
      chk("st_gap_idle", 32'({bus.b_gnt, bus.busy}), 32'h0);
      tick();
      chk("st_b_gnt",  32'({bus.b_gnt, bus.MemWrite}), 32'h3);
      chk("st_b_addr", 32'(bus.a), 32'h044);
      drop(1'b1);
      tick();

      // B LB of a negative byte
      mem[3] = 8'h80;
      drive(1'b1, 1'b1, 1'b0, 9'h003, 32'h0, 3'b000);
      tick();
      $display("txn directed B LB addr=003");
      chk("lb_gnt",  32'(bus.b_gnt),  32'h1);
      chk("lb_f3",   32'(bus.Funct3), 32'h0);
      chk("lb_addr", 32'(bus.a),      32'h003);
      drop(1'b1);
      tick();
      chk("lb_rdata",  bus.b_rdata, 32'hFFFFFF80);
      chk("lb_a_keep", bus.a_rdata, 32'h0);
      tick();

      // randomized traffic against the transaction-level model
      do_reset();
      for (int i = 0; i < 512; i++) shadow[i] = mem[i];
      for (int p = 0; p < 2; p++) begin
         pend[p] = 1'b0; done_c[p] = 0; exp_rd[p] = 32'h0;
         pwe[p] = 1'b0; pad[p] = 9'h0; pwd[p] = 32'h0; pf3[p] = 3'b000;
      end
      g_cyc = -1; v_cyc = -1; free_c = 0; last_b = 1'b1;
      g_b = 1'b0; v_b = 1'b0; g_we = 1'b0; g_ad = 9'h0; g_wd = 32'h0; g_f3 = 3'b000;
      v_data = 32'h0;
      for (int c = 0; c < 400; c++) begin
         if (c == v_cyc) exp_rd[v_b] = v_data;
         chk("r_a_gnt",    32'(bus.a_gnt),    32'(c == g_cyc && !g_b));
         chk("r_b_gnt",    32'(bus.b_gnt),    32'(c == g_cyc && g_b));
         chk("r_a_rvalid", 32'(bus.a_rvalid), 32'(c == v_cyc && !v_b));
         chk("r_b_rvalid", 32'(bus.b_rvalid), 32'(c == v_cyc && v_b));
         chk("r_a_rdata",  bus.a_rdata, exp_rd[0]);
         chk("r_b_rdata",  bus.b_rdata, exp_rd[1]);
         if (c == g_cyc) begin
            chk("r_memread",  32'(bus.MemRead),  32'(!g_we));
            chk("r_memwrite", 32'(bus.MemWrite), 32'(g_we));
            chk("r_addr",     32'(bus.a),        32'(g_ad));
            chk("r_f3",       32'(bus.Funct3),   32'(g_f3));
            if (g_we) chk("r_wd", bus.wd, g_wd);
            pend[g_b] = 1'b0;
            drop(g_b);
         end else begin
            chk("r_strobes_off", 32'({bus.MemRead, bus.MemWrite}), 32'h0);
         end
         for (int p = 0; p < 2; p++) begin
            if (!pend[p] && c >= done_c[p] && $urandom_range(0, 1) == 1) begin
               rwe = 1'($urandom_range(0, 1));
               if (rwe) rf3 = 3'($urandom_range(0, 2));
               else begin
                  case ($urandom_range(0, 4))
                     0: rf3 = 3'b000;
                     1: rf3 = 3'b001;
                     2: rf3 = 3'b010;
                     3: rf3 = 3'b100;
                     default: rf3 = 3'b101;
                  endcase
               end
               rad = 9'($urandom_range(0, 511));
               if (rf3[1:0] == 2'b01) rad[0] = 1'b0;
               if (rf3[1:0] == 2'b10) rad[1:0] = 2'b00;
               rwd = $urandom;
               pend[p] = 1'b1; pwe[p] = rwe; pad[p] = rad; pwd[p] = rwd; pf3[p] = rf3;
               drive(p[0], 1'b1, rwe, rad, rwd, rf3);
            end
         end
         if (c >= free_c && (pend[0] || pend[1])) begin
            wb = pend[1] && (!pend[0] || !last_b);
            last_b = wb;
            g_cyc = c + 1; g_b = wb;
            g_we = pwe[wb]; g_ad = pad[wb]; g_wd = pwd[wb]; g_f3 = pf3[wb];
            if (g_we) begin
               shd_wr(g_ad, g_wd, g_f3);
               free_c = c + 2;
               done_c[wb] = c + 2;
            end else begin
               v_cyc = c + 2; v_b = wb; v_data = shd_rd(g_ad, g_f3);
               free_c = c + 3;
               done_c[wb] = c + 3;
            end
            $display("txn rand cycle=%0d port=%s we=%0d addr=%h f3=%0d data=%h",
                     c + 1, wb ? "B" : "A", g_we, g_ad, g_f3, g_we ? g_wd : v_data);
         end
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
